// File: rtl/quiz_2.sv
// quiz_2: Moore FSM that flags each (overlapping) occurrence of 1011 on a serial stream
module quiz_2 (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic out
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    state_t state, state_next;

    // State register; reset wins over any transition
    always_ff @(posedge clk) begin
        if (rst)
            state <= S0;
        else
            state <= state_next;
    end

    // Longest-prefix transitions; unused encodings fall back to S0
    always_comb begin
        state_next = S0;
        unique case (state)
            S0:      state_next = din ? S1 : S0;
            S1:      state_next = din ? S1 : S2;
            S2:      state_next = din ? S3 : S0;
            S3:      state_next = din ? S4 : S2;
            S4:      state_next = din ? S1 : S2;
            default: state_next = S0;
        endcase
    end

    assign out = (state == S4);

endmodule

// File: tb/tb_quiz_2.sv
// tb_quiz_2: scoreboard bench for the 1011 detector against a sliding-window model
module tb_quiz_2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic out;

    int tests  = 0;
    int failed = 0;

    bit exp_q[$];
    bit hist[$];
    bit e;

    quiz_2 dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .out(out)
    );

    always #5 clk = ~clk;

    // Apply one edge of stimulus and queue the model's expected out after that edge
    task automatic step(input bit r, input bit d);
        bit x;
        @(negedge clk);
        rst = r;
        din = d;
        @(posedge clk);
        if (r) begin
            hist.delete();
            x = 1'b0;
        end else begin
            hist.push_back(d);
            if (hist.size() > 4) void'(hist.pop_front());
            x = (hist.size() == 4) && ({hist[0], hist[1], hist[2], hist[3]} == 4'b1011);
        end
        exp_q.push_back(x);
    endtask

    task automatic feed(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b0, bits[i]);
    endtask

    // Monitor: compare out shortly after every edge that has a queued expectation
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            tests++;
            if (out !== e) begin
                failed++;
                $display("FAIL out_check: t=%0t out=%b expected=%b", $time, out, e);
            end
        end
    end

    initial begin
        step(1'b1, 1'($urandom));
        step(1'b1, 1'($urandom));
        feed(16'b0101_0101, 8);
        feed(16'b1011, 4);
        feed(16'b0, 1);
        step(1'b1, 1'b0);
        feed(16'b101_1011, 7);
        step(1'b1, 1'b0);
        feed(16'b1_1011, 5);
        step(1'b1, 1'b0);
        feed(16'b101, 3);
        step(1'b1, 1'b1);
        feed(16'b1011, 4);
        feed(16'b0, 1);
        step(1'b1, 1'b0);
        feed(16'b1011, 4);
        step(1'b1, 1'b1);
        feed(16'b0, 1);
        feed(16'b1, 1);
        feed(16'b1, 1);
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0));
        @(posedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
